qdec_epb_strip: RTL and testbench
=================================

Name: qdec_epb_strip

Overview:
- Byte-stream conditioner directly upstream of qdec_cabac's bitstreamFetch port.
- Consumes raw HEVC slice-data bytes from the bitstream FIFO and removes emulation-prevention bytes (0x03 following 0x00 0x00).
- Flags start-code prefixes and illegal post-EPB bytes, and presents a registered, full-throughput 8-bit valid/ready stream to CABAC.

Parameters:
EPB_CNT_W, 16, width of the saturating removed-EPB counter
BYTE_CNT_W, 24, width of the saturating emitted-byte counter

Ports:
clk  in  1  clock; all logic is on the rising edge
rst_n  in  1  synchronous active-low reset
clear  in  1  synchronous soft clear, same effect as reset, asserted for one cycle at slice start
din  in  8  raw byte from the bitstream FIFO
din_vld  in  1  din valid
din_rdy  out  1  block accepts din this cycle
dout  out  8  stripped byte to CABAC (bitstreamFetch)
dout_vld  out  1  dout valid
dout_rdy  in  1  CABAC accepts dout
sc_det  out  1  one-cycle pulse: an accepted byte completed 0x00 0x00 0x01
epb_err  out  1  sticky: byte after a removed EPB was greater than 0x03
epb_cnt  out  EPB_CNT_W  number of EPBs removed, saturating
byte_cnt  out  BYTE_CNT_W  number of bytes accepted by CABAC, saturating

Behaviour:
- Reset (rst_n=0 or clear=1 at the edge) clears all state and all outputs:
  - outputs: dout=0, dout_vld=0, din_rdy=0 during reset then 1, sc_det=0, epb_err=0, epb_cnt=0, byte_cnt=0.
  - internal: zero_run=0, after_epb=0, skid buffer empty.
- An input accept is din_vld && din_rdy. An output transfer is dout_vld && dout_rdy.
- Scanner state, updated only on an input accept:
  - zero_run is 2 bits and saturates at 2.
  - after_epb is 1 bit.
- Rules, evaluated per accepted byte b with the pre-update state:
  - zero_run==2 && b==0x03: drop b (not emitted), epb_cnt+=1 (saturating), zero_run<=0, after_epb<=1.
  - Otherwise: emit b.
    - If after_epb && b>0x03, set epb_err (it stays 1 until reset/clear).
    - after_epb<=0.
    - zero_run <= (b==0x00) ? sat(zero_run+1) : 0.
    - If zero_run==2 && b==0x01, pulse sc_det in the next cycle. Detection only; the bytes still pass.
- The sequence 00 00 03 00 00 03 yields two removals: zero_run restarts at 0 after each EPB.
- Output path is a 2-entry skid: a main output register plus one skid register.
  - Emitted bytes enter the main register, or the skid register if the main register is held.
  - din_rdy is registered and equals !skid_full. There is no combinational din_vld→din_rdy or dout_rdy→din_rdy path.
  - Latency: a byte accepted at edge N has dout_vld=1 after edge N, with zero bubbles while dout_rdy=1.
  - Sustained throughput is 1 byte/cycle.
- Handshake rules:
  - dout_vld, once high, holds dout stable until transfer (AXI-stream rule).
  - The block never drops a byte when dout_rdy stalls.
- byte_cnt increments on each output transfer and saturates at all-ones.
- Simultaneous events:
  - Transfer plus new accept in the same cycle: the main register reloads (from skid if occupied, else from din), with no loss and no reordering.
  - Dropped EPB plus output transfer in the same cycle: only the transfer occurs, and din_rdy stays 1.
- Reset or clear mid-stream discards buffered bytes and scanner state.
  - dout_vld is 0 in the first cycle after the edge.
  - clear has priority over a simultaneous accept.

Test Plan:
- Pass-through: feed 0x12 0x34 0x00 0x05 with dout_rdy=1 → dout 12 34 00 05 on consecutive cycles, first valid 1 cycle after accept; byte_cnt=4, epb_cnt=0.
- EPB strip: feed 00 00 03 01 00 00 03 00 00 03 02 → dout 00 00 01 00 00 00 00 02; epb_cnt=3, epb_err=0, sc_det=0.
- Start code and error:
  - 00 00 01 → sc_det pulses once, 3 bytes emitted.
  - 00 00 03 07 → 07 emitted, epb_err=1 and sticky; epb_cnt=1.
- Backpressure: continuous 16-byte ramp 0x00..0x0F with dout_rdy toggling 1,0,0,1 pattern → all 16 bytes out in order, dout stable while stalled, din_rdy low only when skid full, no duplicates.
- Clear mid-stream: stall dout_rdy with 2 bytes buffered, pulse clear → next cycle dout_vld=0, counters 0. Then 00 03 → emitted as 00 03, since zero_run was cleared.
- Saturation: force 2^16+5 EPB sequences (or use a reduced EPB_CNT_W=4 build with 20 EPBs) → epb_cnt holds at all-ones.

Source files
------------

// File: rtl/qdec_epb_strip.sv
// qdec_epb_strip
// Byte-stream conditioner that sits in front of the CABAC bitstream fetch port.
// Raw slice-data bytes come in, emulation-prevention bytes (0x03 after two
// zero bytes) are removed, start-code prefixes and illegal post-EPB bytes are
// flagged, and the surviving bytes leave through a registered two-entry skid
// so that both handshake directions are fully registered at one byte/cycle.

module qdec_epb_strip #(
    parameter int EPB_CNT_W  = 16,
    parameter int BYTE_CNT_W = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic [7:0]            din,
    input  logic                  din_vld,
    output logic                  din_rdy,
    output logic [7:0]            dout,
    output logic                  dout_vld,
    input  logic                  dout_rdy,
    output logic                  sc_det,
    output logic                  epb_err,
    output logic [EPB_CNT_W-1:0]  epb_cnt,
    output logic [BYTE_CNT_W-1:0] byte_cnt
);

    // Scanner state: run of consecutive zero bytes (saturating at 2) and a
    // flag remembering that the previous accepted byte was a removed EPB.
    logic [1:0]            zero_run_q, zero_run_d;
    logic                  after_epb_q, after_epb_d;

    // Output side: main register drives the port, skid catches one byte
    // while the main register is held by a stalled consumer.
    logic [7:0]            main_q, main_d;
    logic                  main_vld_q, main_vld_d;
    logic [7:0]            skid_q, skid_d;
    logic                  skid_vld_q, skid_vld_d;
    logic                  din_rdy_q, din_rdy_d;

    // Status outputs and statistics.
    logic                  sc_det_q, sc_det_d;
    logic                  epb_err_q, epb_err_d;
    logic [EPB_CNT_W-1:0]  epb_cnt_q, epb_cnt_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;

    // Handshake qualifiers shared by all next-state blocks.
    logic                  accept;
    logic                  xfer;
    logic                  is_epb;
    logic                  emit;

    assign accept = din_vld && din_rdy_q;
    assign xfer   = main_vld_q && dout_rdy;
    assign is_epb = (zero_run_q == 2'd2) && (din == 8'h03);
    assign emit   = accept && !is_epb;

    // Per-byte scanner: EPB removal, start-code detection and error flagging.
    always_comb begin
        zero_run_d  = zero_run_q;
        after_epb_d = after_epb_q;
        sc_det_d    = 1'b0;
        epb_err_d   = epb_err_q;
        epb_cnt_d   = epb_cnt_q;
        if (accept) begin
            if (is_epb) begin
                zero_run_d  = 2'd0;
                after_epb_d = 1'b1;
                if (epb_cnt_q != {EPB_CNT_W{1'b1}}) begin
                    epb_cnt_d = epb_cnt_q + EPB_CNT_W'(1);
                end
            end else begin
                if (after_epb_q && (din > 8'h03)) begin
                    epb_err_d = 1'b1;
                end
                after_epb_d = 1'b0;
                if (din == 8'h00) begin
                    zero_run_d = (zero_run_q == 2'd2) ? 2'd2 : (zero_run_q + 2'd1);
                end else begin
                    zero_run_d = 2'd0;
                end
                sc_det_d = (zero_run_q == 2'd2) && (din == 8'h01);
            end
        end
    end

    // Two-entry skid: refill main from skid first so order is preserved,
    // park new bytes in skid only while main is held by a stall.
    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (xfer || !main_vld_q) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
                if (emit) begin
                    skid_d     = din;
                    skid_vld_d = 1'b1;
                end
            end else if (emit) begin
                main_d     = din;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (emit) begin
            skid_d     = din;
            skid_vld_d = 1'b1;
        end
        din_rdy_d = !skid_vld_d;
    end

    // Saturating count of bytes actually taken by the consumer.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        if (xfer && (byte_cnt_q != {BYTE_CNT_W{1'b1}})) begin
            byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
        end
    end

    // All state registers; reset and soft clear both wipe everything.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            zero_run_q  <= 2'd0;
            after_epb_q <= 1'b0;
            main_q      <= 8'h00;
            main_vld_q  <= 1'b0;
            skid_q      <= 8'h00;
            skid_vld_q  <= 1'b0;
            din_rdy_q   <= 1'b0;
            sc_det_q    <= 1'b0;
            epb_err_q   <= 1'b0;
            epb_cnt_q   <= '0;
            byte_cnt_q  <= '0;
        end else begin
            zero_run_q  <= zero_run_d;
            after_epb_q <= after_epb_d;
            main_q      <= main_d;
            main_vld_q  <= main_vld_d;
            skid_q      <= skid_d;
            skid_vld_q  <= skid_vld_d;
            din_rdy_q   <= din_rdy_d;
            sc_det_q    <= sc_det_d;
            epb_err_q   <= epb_err_d;
            epb_cnt_q   <= epb_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end

    assign din_rdy  = din_rdy_q;
    assign dout     = main_q;
    assign dout_vld = main_vld_q;
    assign sc_det   = sc_det_q;
    assign epb_err  = epb_err_q;
    assign epb_cnt  = epb_cnt_q;
    assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_qdec_epb_strip.sv
// tb_qdec_epb_strip
// Drives byte streams into qdec_epb_strip and compares every output cycle
// against a byte-level reference model: a queue of bytes that should be in
// flight, plus the expected counters and flags.

module tb_qdec_epb_strip;

    localparam int EPB_W  = 4;
    localparam int BYTE_W = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic [7:0]        din = 8'h00;
    logic              din_vld = 1'b0;
    logic              din_rdy;
    logic [7:0]        dout;
    logic              dout_vld;
    logic              dout_rdy = 1'b0;
    logic              sc_det;
    logic              epb_err;
    logic [EPB_W-1:0]  epb_cnt;
    logic [BYTE_W-1:0] byte_cnt;

    qdec_epb_strip #(
        .EPB_CNT_W  (EPB_W),
        .BYTE_CNT_W (BYTE_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .din      (din),
        .din_vld  (din_vld),
        .din_rdy  (din_rdy),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .sc_det   (sc_det),
        .epb_err  (epb_err),
        .epb_cnt  (epb_cnt),
        .byte_cnt (byte_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state.
    logic [7:0] exp_q[$];
    logic [7:0] out_log[$];
    int         m_zero;
    bit         m_after;
    int         m_epb;
    int         m_bytes;
    bit         m_err;
    bit         m_sc;
    bit         m_post_reset;
    int         sc_seen;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void modelReset();
        exp_q.delete();
        m_zero = 0;
        m_after = 1'b0;
        m_epb = 0;
        m_bytes = 0;
        m_err = 1'b0;
        m_sc = 1'b0;
    endfunction

    function automatic void modelAccept(input logic [7:0] b);
        if (m_zero == 2 && b == 8'h03) begin
            if (m_epb < (1 << EPB_W) - 1) m_epb++;
            m_zero = 0;
            m_after = 1'b1;
        end else begin
            if (m_after && b > 8'h03) m_err = 1'b1;
            m_after = 1'b0;
            if (m_zero == 2 && b == 8'h01) m_sc = 1'b1;
            m_zero = (b == 8'h00) ? ((m_zero < 2) ? m_zero + 1 : 2) : 0;
            exp_q.push_back(b);
        end
    endfunction

    // Compare all DUT outputs with the model, one cycle's worth.
    task automatic checkOutput();
        checkValue("dout_vld", dout_vld, (exp_q.size() > 0));
        if (exp_q.size() > 0) checkValue("dout", dout, exp_q[0]);
        else if (m_post_reset) checkValue("dout_after_reset", dout, 8'h00);
        checkValue("din_rdy", din_rdy, m_post_reset ? 1'b0 : (exp_q.size() < 2));
        checkValue("sc_det", sc_det, m_sc);
        checkValue("epb_cnt", epb_cnt, m_epb);
        checkValue("epb_err", epb_err, m_err);
        checkValue("byte_cnt", byte_cnt, m_bytes);
        if (sc_det) sc_seen++;
    endtask

    // One clock of stimulus; the model is advanced by the handshakes that
    // were visible just before the edge.
    task automatic applyStimulus(input bit clr, input bit v, input logic [7:0] d,
                                 input bit r, output bit acc);
        bit         xfer;
        logic [7:0] obs;
        clear = clr;
        din_vld = v;
        din = d;
        dout_rdy = r;
        #1;
        acc = v && din_rdy;
        xfer = dout_vld && r;
        obs = dout;
        @(posedge clk);
        #1;
        clear = 1'b0;
        m_sc = 1'b0;
        m_post_reset = 1'b0;
        if (clr) begin
            modelReset();
            m_post_reset = 1'b1;
            acc = 1'b0;
        end else begin
            if (xfer) begin
                out_log.push_back(obs);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                if (m_bytes < (1 << BYTE_W) - 1) m_bytes++;
            end
            if (acc) modelAccept(d);
        end
        checkOutput();
    endtask

    task automatic doReset();
        din_vld = 1'b0;
        clear = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
        out_log.delete();
        m_post_reset = 1'b1;
        sc_seen = 0;
        checkOutput();
    endtask

    // mode 0: consumer always ready; 1: ready pattern 1,0,0,1; 2: random.
    task automatic feedStream(input logic [7:0] s[$], input int mode);
        int idx = 0;
        int cyc = 0;
        bit acc;
        bit v;
        bit r;
        while ((idx < s.size() || exp_q.size() > 0) && cyc < 2000) begin
            v = (idx < s.size());
            if (mode == 2 && $urandom_range(0, 3) == 0) v = 1'b0;
            case (mode)
                0: r = 1'b1;
                1: r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: r = ($urandom_range(0, 2) != 0);
            endcase
            applyStimulus(1'b0, v, v ? s[idx] : 8'h00, r, acc);
            if (acc) idx++;
            cyc++;
        end
        din_vld = 1'b0;
        checkValue("stream_consumed", idx, s.size());
        checkValue("stream_drained", exp_q.size(), 0);
    endtask

    task automatic checkLog(input string tag, input logic [7:0] e[$]);
        checkValue({tag, "_len"}, out_log.size(), e.size());
        for (int i = 0; i < e.size() && i < out_log.size(); i++)
            checkValue(tag, out_log[i], e[i]);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] s[$];
        logic [7:0] e[$];
        bit acc;
        int n;
        int r;

        $display("[TB] start");

        // Reset state
        doReset();

        // Pass-through
        s = '{8'h12, 8'h34, 8'h00, 8'h05};
        feedStream(s, 0);
        checkLog("pass_log", s);
        checkValue("pass_byte_cnt", byte_cnt, 4);
        checkValue("pass_epb_cnt", epb_cnt, 0);

        // EPB strip
        doReset();
        s = '{8'h00, 8'h00, 8'h03, 8'h01, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h03, 8'h02};
        e = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
        feedStream(s, 0);
        checkLog("strip_log", e);
        checkValue("strip_epb_cnt", epb_cnt, 3);
        checkValue("strip_epb_err", epb_err, 0);
        checkValue("strip_sc_count", sc_seen, 0);

        // Start code
        doReset();
        s = '{8'h00, 8'h00, 8'h01};
        feedStream(s, 0);
        checkLog("sc_log", s);
        checkValue("sc_count", sc_seen, 1);

        // Error after EPB, then sticky
        doReset();
        s = '{8'h00, 8'h00, 8'h03, 8'h07};
        e = '{8'h00, 8'h00, 8'h07};
        feedStream(s, 0);
        checkLog("err_log", e);
        checkValue("err_flag", epb_err, 1);
        checkValue("err_epb_cnt", epb_cnt, 1);
        s = '{8'h11};
        feedStream(s, 0);
        checkValue("err_sticky", epb_err, 1);

        // Backpressure ramp
        doReset();
        s.delete();
        for (int i = 0; i < 16; i++) s.push_back(8'(i));
        feedStream(s, 1);
        checkLog("ramp_log", s);
        checkValue("ramp_byte_cnt", byte_cnt, 16);

        // Clear mid-stream with two bytes buffered and a competing accept
        n = 0;
        for (int i = 0; i < 10 && n < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, acc);
            if (acc) n++;
        end
        checkValue("clr_buffered", n, 2);
        checkValue("clr_pre_rdy", din_rdy, 0);
        applyStimulus(1'b1, 1'b1, 8'h03, 1'b0, acc);
        checkValue("clr_dout_vld", dout_vld, 0);
        checkValue("clr_byte_cnt", byte_cnt, 0);
        out_log.delete();
        s = '{8'h00, 8'h03};
        feedStream(s, 0);
        checkLog("clr_log", s);
        checkValue("clr_epb_cnt", epb_cnt, 0);

        // EPB counter saturation
        doReset();
        s.delete();
        for (int i = 0; i < 20; i++) begin
            s.push_back(8'h00);
            s.push_back(8'h00);
            s.push_back(8'h03);
        end
        feedStream(s, 0);
        checkValue("sat_epb_cnt", epb_cnt, (1 << EPB_W) - 1);
        checkValue("sat_log_len", out_log.size(), 40);

        // Randomized streams; byte_cnt ends saturated
        for (int k = 0; k < 3; k++) begin
            s.delete();
            for (int i = 0; i < 60; i++) begin
                r = $urandom_range(0, 5);
                case (r)
                    0, 1, 2: s.push_back(8'h00);
                    3:       s.push_back(8'h03);
                    4:       s.push_back(8'h01);
                    default: s.push_back(8'($urandom));
                endcase
            end
            feedStream(s, 2);
        end
        checkValue("sat_byte_cnt", byte_cnt, (1 << BYTE_W) - 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
